// File: rtl/posit_ema_sequencer.sv
// posit_ema_sequencer: job-level initiator for the PositEMA_top multiply-accumulate core.
// Accepts a dot-product job, clears the core, streams operand pairs into it,
// counts result strobes and returns the final posit sum on a valid/ready port.
// Optional build macro EMA_TIMEOUT_EN adds a DRAIN watchdog and the res_err output.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a job; job_ready high
// S_CLEAR  | one-cycle synchronous clear pulse to the core
// S_ISSUE  | forwarding operand pairs until len have been issued
// S_DRAIN  | all pairs issued, waiting for the remaining result strobes
// S_RESULT | res_valid high, res_data held until res_ready
module posit_ema_sequencer #(
  parameter int N_W = 8
`ifdef EMA_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 63
`endif
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           job_valid,
  output logic           job_ready,
  input  logic [N_W-1:0] job_len,
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [15:0]    op_a,
  input  logic [15:0]    op_b,
  output logic           ema_clear,
  output logic           ema_inValid,
  output logic [15:0]    ema_A,
  output logic [15:0]    ema_B,
  input  logic [15:0]    ema_positOut,
  input  logic           ema_outValid,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [15:0]    res_data,
`ifdef EMA_TIMEOUT_EN
  output logic           res_err,
`endif
  output logic           busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_DRAIN,
    S_RESULT
  } state_e;

  localparam logic [N_W-1:0] ONE = N_W'(1);

  state_e         state_q, state_d;
  logic [N_W-1:0] len_q, len_d;
  logic [N_W-1:0] issued_q, issued_d;
  logic [N_W-1:0] done_q, done_d;
  logic           ema_clear_q, ema_clear_d;
  logic           ema_inValid_q, ema_inValid_d;
  logic [15:0]    ema_A_q, ema_A_d;
  logic [15:0]    ema_B_q, ema_B_d;
  logic           res_valid_q, res_valid_d;
  logic [15:0]    res_data_q, res_data_d;
  logic           busy_q, busy_d;
  logic           strobe_ok;
  logic           strobe_last;

`ifdef EMA_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            res_err_q, res_err_d;
`endif

  // State, counters and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      issued_q      <= '0;
      done_q        <= '0;
      ema_clear_q   <= 1'b0;
      ema_inValid_q <= 1'b0;
      ema_A_q       <= 16'h0000;
      ema_B_q       <= 16'h0000;
      res_valid_q   <= 1'b0;
      res_data_q    <= 16'h0000;
      busy_q        <= 1'b0;
`ifdef EMA_TIMEOUT_EN
      to_cnt_q      <= TO_LOAD;
      res_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      issued_q      <= issued_d;
      done_q        <= done_d;
      ema_clear_q   <= ema_clear_d;
      ema_inValid_q <= ema_inValid_d;
      ema_A_q       <= ema_A_d;
      ema_B_q       <= ema_B_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      busy_q        <= busy_d;
`ifdef EMA_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      res_err_q     <= res_err_d;
`endif
    end
  end

  // Next-state, counter updates and handshake decode.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    issued_d      = issued_q;
    done_d        = done_q;
    ema_clear_d   = 1'b0;
    ema_inValid_d = 1'b0;
    ema_A_d       = ema_A_q;
    ema_B_d       = ema_B_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
`ifdef EMA_TIMEOUT_EN
    to_cnt_d      = TO_LOAD;
    res_err_d     = res_err_q;
`endif

    job_ready = (state_q == S_IDLE);
    op_ready  = (state_q == S_ISSUE) && (issued_q < len_q);

    // Strobes only count while a job is in flight and done is below len;
    // anything else is a spurious pulse from the core.
    strobe_ok   = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) &&
                  ema_outValid && (done_q < len_q);
    strobe_last = strobe_ok && ((done_q + ONE) == len_q);

    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          len_d       = job_len;
          issued_d    = '0;
          done_d      = '0;
          ema_clear_d = 1'b1;
          state_d     = S_CLEAR;
        end
      end

      S_CLEAR: begin
        if (len_q == '0) begin
          res_valid_d = 1'b1;
          res_data_d  = 16'h0000;
          state_d     = S_RESULT;
        end else begin
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (op_valid && op_ready) begin
          ema_A_d       = op_a;
          ema_B_d       = op_b;
          ema_inValid_d = 1'b1;
          issued_d      = issued_q + ONE;
          if ((issued_q + ONE) == len_q) begin
            state_d = S_DRAIN;
          end
        end
        if (strobe_ok) begin
          done_d = done_q + ONE;
        end
        if (strobe_last) begin
          res_data_d  = ema_positOut;
          res_valid_d = 1'b1;
          state_d     = S_RESULT;
        end
      end

      S_DRAIN: begin
`ifdef EMA_TIMEOUT_EN
        to_cnt_d = to_cnt_q - TO_ONE;
`endif
        if (strobe_ok) begin
          done_d = done_q + ONE;
`ifdef EMA_TIMEOUT_EN
          to_cnt_d = TO_LOAD;
`endif
        end
        if (strobe_last) begin
          res_data_d  = ema_positOut;
          res_valid_d = 1'b1;
          state_d     = S_RESULT;
        end
`ifdef EMA_TIMEOUT_EN
        else if (!strobe_ok && (to_cnt_q == TO_ONE)) begin
          // The core went silent: report NaR and flag the error.
          res_data_d  = 16'h8000;
          res_valid_d = 1'b1;
          res_err_d   = 1'b1;
          state_d     = S_RESULT;
        end
`endif
      end

      S_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
`ifdef EMA_TIMEOUT_EN
          res_err_d   = 1'b0;
`endif
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign ema_clear   = ema_clear_q;
  assign ema_inValid = ema_inValid_q;
  assign ema_A       = ema_A_q;
  assign ema_B       = ema_B_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign busy        = busy_q;
`ifdef EMA_TIMEOUT_EN
  assign res_err     = res_err_q;
`endif

endmodule

// File: tb/tb_posit_ema_sequencer.sv
// Bench for posit_ema_sequencer: table of jobs plus hand-written reset and
// spurious-strobe sequences. A small core model answers each ema_inValid
// with a running sum after a configurable latency; expected job results are
// queued when a job is launched and popped at the result handshake.
`timescale 1ns/1ps
module tb_posit_ema_sequencer;
  localparam int N_W         = 8;
  localparam int TIMEOUT_CYC = 63;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           job_valid = 1'b0;
  logic           job_ready;
  logic [N_W-1:0] job_len = '0;
  logic           op_valid = 1'b0;
  logic           op_ready;
  logic [15:0]    op_a = '0;
  logic [15:0]    op_b = '0;
  logic           ema_clear;
  logic           ema_inValid;
  logic [15:0]    ema_A;
  logic [15:0]    ema_B;
  logic [15:0]    ema_positOut = '0;
  logic           ema_outValid = 1'b0;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [15:0]    res_data;
  logic           busy;
`ifdef EMA_TIMEOUT_EN
  logic           res_err;
`endif

  posit_ema_sequencer #(.N_W(N_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .job_len      (job_len),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .ema_clear    (ema_clear),
    .ema_inValid  (ema_inValid),
    .ema_A        (ema_A),
    .ema_B        (ema_B),
    .ema_positOut (ema_positOut),
    .ema_outValid (ema_outValid),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
`ifdef EMA_TIMEOUT_EN
    .res_err      (res_err),
`endif
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Core model configuration (written by the stimulus process only).
  int          core_lat       = 3;
  bit          core_mute      = 1'b0;
  bit          core_fixed_en  = 1'b0;
  logic [15:0] core_fixed_val = '0;
  int          spur_req       = 0;

  // Core model state (written by the model process only).
  typedef struct {
    int          due;
    logic [15:0] val;
  } pend_t;
  pend_t       pend[$];
  logic [15:0] core_acc        = '0;
  int          inval_cnt       = 0;
  int          last_strobe_cyc = 0;
  int          spur_done       = 0;

  always @(negedge clock) begin
    pend_t p;
    ema_outValid = 1'b0;
    if (!reset) begin
      pend.delete();
      core_acc = '0;
    end else begin
      if (ema_clear) core_acc = '0;
      if (ema_inValid) begin
        inval_cnt++;
        core_acc = core_acc + (ema_A ^ {ema_B[7:0], ema_B[15:8]});
        if (!core_mute) begin
          p.due = cyc + core_lat;
          p.val = core_fixed_en ? core_fixed_val : core_acc;
          pend.push_back(p);
        end
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        ema_outValid    = 1'b1;
        ema_positOut    = pend[0].val;
        last_strobe_cyc = cyc;
        void'(pend.pop_front());
      end else if (spur_req != spur_done) begin
        ema_outValid = 1'b1;
        ema_positOut = 16'hDEAD;
        spur_done++;
      end
    end
  end

  typedef struct {
    int          len;
    int          gap;
    int          hold;
    int          lat;
    logic [15:0] base;
    bit          fixed_en;
    logic [15:0] exp_res;
    bit          use_sum;
    bit          spur;
    bit          mute;
  } vec_t;

  logic [15:0] sb[$];

  function automatic logic [15:0] gen_a(input logic [15:0] base, input int k);
    return base + 16'(k) * 16'h0111;
  endfunction

  function automatic logic [15:0] gen_b(input logic [15:0] base, input int k);
    return base ^ (16'(k) * 16'h0203);
  endfunction

  task automatic run_job(input vec_t v);
    logic [15:0] a, b, acc, exp_v, exp_pop, prev_a, prev_b;
    int inv0, ph, w, i, last_hs_cyc;
    bit hs;
    acc = '0;
    for (int k = 0; k < v.len; k++) begin
      a = gen_a(v.base, k);
      b = gen_b(v.base, k);
      acc = acc + (a ^ {b[7:0], b[15:8]});
    end
    exp_v = v.use_sum ? acc : v.exp_res;
    core_lat       = v.lat;
    core_mute      = v.mute;
    core_fixed_en  = v.fixed_en;
    core_fixed_val = v.exp_res;

    chk("job_ready_idle", job_ready, 1);
    sb.push_back(exp_v);
    inv0 = inval_cnt;
    job_valid = 1'b1;
    job_len   = N_W'(v.len);
    @(negedge clock);
    job_valid = 1'b0;
    chk("clear_pulse", ema_clear, 1);
    chk("busy_after_accept", busy, 1);
    chk("job_ready_busy", job_ready, 0);
    @(negedge clock);
    chk("clear_single", ema_clear, 0);
    if (v.len == 0) begin
      chk("zero_len_res_t2", res_valid, 1);
      chk("zero_len_op_ready", op_ready, 0);
    end else begin
      chk("op_ready_t2", op_ready, 1);
    end

    i = 0; ph = 0; w = 0; prev_a = '0; prev_b = '0;
    while (i < v.len && w < 500) begin
      a = gen_a(v.base, i);
      b = gen_b(v.base, i);
      op_valid = (ph == 0);
      op_a = a;
      op_b = b;
      hs = op_valid && op_ready;
      @(negedge clock);
      if (hs) begin
        chk("inValid_pulse", ema_inValid, 1);
        chk("ema_A", ema_A, a);
        chk("ema_B", ema_B, b);
        prev_a = a; prev_b = b;
        i++;
      end else begin
        chk("inValid_gap", ema_inValid, 0);
        if (i > 0) chk("ema_A_hold", ema_A, prev_a);
        if (i > 0) chk("ema_B_hold", ema_B, prev_b);
      end
      ph = (ph >= v.gap) ? 0 : ph + 1;
      w++;
    end
    op_valid = 1'b0;
    if (i < v.len) chk("issue_budget", i, v.len);
    last_hs_cyc = cyc;
    if (v.len > 0) chk("op_ready_after_issue", op_ready, 0);

    w = 0;
    while (!res_valid && w < 300) begin
      @(negedge clock);
      w++;
    end
    chk("res_valid_seen", res_valid, 1);
    if (v.mute) chk("timeout_latency", cyc - last_hs_cyc, TIMEOUT_CYC);
    else if (v.len > 0) chk("res_latency", cyc - last_strobe_cyc, 1);
    chk("inValid_count", inval_cnt - inv0, v.len);
`ifdef EMA_TIMEOUT_EN
    chk("res_err", res_err, 32'(v.mute));
`endif
    if (v.spur) spur_req++;

    for (int h = 0; h < v.hold; h++) begin
      job_valid = 1'b1;
      job_len   = N_W'(7);
      @(negedge clock);
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, exp_v);
      chk("hold_job_ready", job_ready, 0);
    end
    job_valid = 1'b0;
    res_ready = 1'b1;
    exp_pop = sb.pop_front();
    chk("res_data", res_data, exp_pop);
    @(negedge clock);
    res_ready = 1'b0;
    chk("res_valid_drop", res_valid, 0);
    chk("idle_job_ready", job_ready, 1);
    chk("idle_busy", busy, 0);
`ifdef EMA_TIMEOUT_EN
    chk("res_err_cleared", res_err, 0);
`endif
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_job_ready"}, job_ready, 1);
    chk({tag, "_op_ready"}, op_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ema_clear"}, ema_clear, 0);
    chk({tag, "_ema_inValid"}, ema_inValid, 0);
    chk({tag, "_ema_A"}, ema_A, 16'h0000);
    chk({tag, "_ema_B"}, ema_B, 16'h0000);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"}, res_data, 16'h0000);
`ifdef EMA_TIMEOUT_EN
    chk({tag, "_res_err"}, res_err, 0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;

    tbl.push_back('{len:1, gap:0, hold:0, lat:3, base:16'h3FFF, fixed_en:1'b1,
                    exp_res:16'h4123, use_sum:1'b0, spur:1'b0, mute:1'b0});
    tbl.push_back('{len:4, gap:0, hold:3, lat:2, base:16'h1000, fixed_en:1'b0,
                    exp_res:16'h0000, use_sum:1'b1, spur:1'b1, mute:1'b0});
    tbl.push_back('{len:0, gap:0, hold:1, lat:1, base:16'h0000, fixed_en:1'b0,
                    exp_res:16'h0000, use_sum:1'b0, spur:1'b0, mute:1'b0});
    tbl.push_back('{len:3, gap:2, hold:5, lat:4, base:16'h2345, fixed_en:1'b0,
                    exp_res:16'h0000, use_sum:1'b1, spur:1'b0, mute:1'b0});
    tbl.push_back('{len:5, gap:1, hold:0, lat:1, base:16'h7A01, fixed_en:1'b0,
                    exp_res:16'h0000, use_sum:1'b1, spur:1'b0, mute:1'b0});
`ifdef EMA_TIMEOUT_EN
    tbl.push_back('{len:2, gap:0, hold:2, lat:1, base:16'h0F0F, fixed_en:1'b0,
                    exp_res:16'h8000, use_sum:1'b0, spur:1'b0, mute:1'b1});
`endif

    repeat (3) @(negedge clock);
    chk_reset_vals("por");
    reset = 1'b1;
    @(negedge clock);
    chk("job_ready_after_por", job_ready, 1);

    foreach (tbl[k]) begin
      run_job(tbl[k]);
    end

    // Abandon a len=4 job after two accepted pairs.
    core_lat = 3; core_mute = 1'b0; core_fixed_en = 1'b0;
    job_valid = 1'b1;
    job_len   = N_W'(4);
    @(negedge clock);
    job_valid = 1'b0;
    @(negedge clock);
    chk("rst_seq_op_ready", op_ready, 1);
    op_valid = 1'b1; op_a = 16'h1111; op_b = 16'h2222;
    @(negedge clock);
    op_a = 16'h3333; op_b = 16'h4444;
    @(negedge clock);
    op_valid = 1'b0;
    chk("rst_seq_ema_A_before", ema_A, 16'h3333);
    reset = 1'b0;
    #1;
    chk_reset_vals("midjob");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_release_job_ready", job_ready, 1);
    chk("rst_release_res_valid", res_valid, 0);

    v = '{len:1, gap:0, hold:1, lat:2, base:16'h5A5A, fixed_en:1'b0,
          exp_res:16'h0000, use_sum:1'b1, spur:1'b0, mute:1'b0};
    run_job(v);

    // A strobe while idle must not start anything.
    spur_req++;
    repeat (3) @(negedge clock);
    chk("idle_strobe_busy", busy, 0);
    chk("idle_strobe_res_valid", res_valid, 0);
    chk("idle_strobe_job_ready", job_ready, 1);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/posit_ema_sequencer.md
# posit_ema_sequencer

Job-level initiator that drives the `PositEMA_top` exact multiply-accumulate core.
- Accepts a dot-product job (length N), clears the core's accumulator, and streams N operand pairs from an upstream source into the core.
- Counts the core's result strobes and returns the final 16-bit posit sum through a valid/ready result port.
- Sits between the vision pipeline's operand fetch and the posit EMA core, replacing ad-hoc reset/inValid sequencing.

## Interface
- `N_W`, 8: width of job length; max N = 2^N_W−1.
- `TIMEOUT`, 63: idle-cycle limit in DRAIN (used only with `EMA_TIMEOUT_EN`).
- `clock`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `job_valid`  in  1  job request.
- `job_ready`  out  1  high only in IDLE.
- `job_len`  in  N_W  number of operand pairs; 0 is legal.
- `op_valid`  in  1  operand pair available.
- `op_ready`  out  1  pair accepted when `op_valid && op_ready`.
- `op_a`, `op_b`  in  16  posit operands.
- `ema_clear`  out  1  active-high synchronous clear to the core's `reset`.
- `ema_inValid`  out  1  to core `io_inValid`.
- `ema_A`, `ema_B`  out  16  to core `io_A`/`io_B`.
- `ema_positOut`  in  16  from core `io_positOut`.
- `ema_outValid`  in  1  from core `io_outValid`; one pulse per product, carrying the running sum.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed when `res_valid && res_ready`.
- `res_data`  out  16  final posit sum.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, CLEAR, ISSUE, DRAIN, RESULT.
- IDLE:
  - `job_ready=1`.
  - On `job_valid`: latch `job_len` into `len`, zero `issued`/`done`, go to CLEAR.
- CLEAR:
  - `ema_clear=1` for exactly one cycle.
  - Next state: RESULT with `res_data=16'h0000` if `len==0`, else ISSUE.
- ISSUE:
  - `op_ready = (issued < len)`.
  - Each handshake registers `op_a`/`op_b` into `ema_A`/`ema_B`, pulses `ema_inValid` for one cycle, and increments `issued`.
  - When `issued` reaches `len`, go to DRAIN.
- DRAIN: `op_ready=0`; wait for the remaining strobes.
- Strobe counting, in ISSUE and DRAIN:
  - Each `ema_outValid` increments `done`.
  - The strobe that makes `done==len` captures `ema_positOut` into `res_data` and moves to RESULT (from ISSUE or DRAIN).
- RESULT:
  - `res_valid=1`; `res_data` is held stable until `res_ready`.
  - On handshake go to IDLE and drop `res_valid`.
- Boundaries:
  - `ema_outValid` in IDLE, CLEAR or RESULT is ignored.
  - Strobes beyond `len` are ignored.
  - `ema_A`/`ema_B` hold their last value when `ema_inValid=0`.
  - `job_valid` outside IDLE is not accepted.
  - `op_valid` outside ISSUE is not accepted.
- Counters are N_W bits wide; they cannot wrap because `issued` and `done` are both capped at `len`.

## Timing
- Reset (async assert, sync release): state IDLE; `job_ready=1`; all other outputs 0 (`ema_A`/`ema_B`/`res_data` = 16'h0000).
- Reset mid-job: the job is abandoned immediately; no result is produced.
- Job accept at cycle t: `ema_clear` high at t+1; first `op_ready` at t+2.
- `ema_inValid` rises one cycle after each op handshake; throughput is 1 pair/cycle.
- `res_valid` rises one cycle after the final `ema_outValid`.
- `len==0`: `res_valid` at t+2.
- All outputs are registered except `op_ready` and `job_ready`, which are decoded from registered state and counters.

## Configuration
- Macro: `EMA_TIMEOUT_EN`.
- Defined:
  - Adds output `res_err` (1 bit, reset 0) and a DRAIN idle counter, cleared on each `ema_outValid`.
  - If the counter reaches `TIMEOUT` without a strobe: go to RESULT with `res_data=16'h8000` (NaR) and `res_err=1`.
  - `res_err` clears on the result handshake.
- Undefined: no `res_err` port; DRAIN waits indefinitely.

## Test plan
- Single pair: `len=1`, A=B=16'h3FFF, core model answers 16'h4123 three cycles later.
  - Expect one `ema_clear` pulse and one `ema_inValid` with A/B=16'h3FFF.
  - Expect `res_data=16'h4123` with `res_valid` one cycle after the strobe.
- Streaming: `len=4`, op_valid held high.
  - Expect 4 consecutive `ema_inValid` cycles.
  - Result equals `ema_positOut` at the 4th strobe; a 5th spurious strobe is ignored.
- Zero length: `len=0`.
  - Expect no `ema_inValid`, `res_valid` at t+2 with 16'h0000.
- Backpressure: `op_valid` gapped 1-on/2-off, and `res_ready` low for 5 cycles.
  - Expect `res_data`/`res_valid` stable and `job_ready=0` until the handshake.
- Reset during ISSUE after 2 of 4 pairs.
  - Expect outputs at their reset values at once and `job_ready=1` after release.
  - A following `len=1` job completes correctly.
- With `EMA_TIMEOUT_EN`, core never strobes.
  - Expect `res_valid` with `res_data=16'h8000` and `res_err=1` after TIMEOUT DRAIN cycles.
  - Expect `res_err` cleared after `res_ready`.
